// File: rtl/imem_if.sv
// Fetch request, response and program-loader signals shared by the fetch stage
// and the instruction-memory responder.
interface imem_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              flush;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_err;
  logic              rsp_ready;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  modport master (
    output req_valid, req_addr, flush, rsp_ready, ld_we, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready, ld_we, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory with fixed read latency, an in-order response FIFO sized by
// an occupancy credit, pipeline flush and a word-write program loader.
module imem_responder #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input logic   clk,
  input logic   rst_n,
  imem_if.slave bus
);
  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W:0]   DEPTH_LIM = (IDX_W + 1)'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              err;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  entry_t            fifo_q [FIFO_DEPTH];
  entry_t            in_e, push_e, head_e;
  logic [IDX_W-1:0]  in_idx, ld_idx;
  logic              in_err, accept, pop, push_v, ld_hit;
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d, wr_idx;
  logic [CNT_W-1:0]  cnt_q, cnt_d, occ_q, occ_d;
  logic              unused_ld_lo;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Occupancy counts in-flight plus buffered entries, so an accepted request always has a FIFO slot.
  assign bus.req_ready = rst_n && (occ_q < FULL_CNT);
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = rst_n && (cnt_q != '0);
  assign pop           = bus.rsp_valid && bus.rsp_ready;

  assign head_e        = fifo_q[rd_q];
  assign bus.rsp_data  = rst_n ? head_e.data : '0;
  assign bus.rsp_addr  = rst_n ? head_e.addr : '0;
  assign bus.rsp_err   = rst_n && head_e.err;

  assign in_idx = bus.req_addr[ADDR_W-1:2];
  assign in_err = (bus.req_addr[1:0] != 2'b00) || ({1'b0, in_idx} >= DEPTH_LIM);

  always_comb begin
    in_e.addr = bus.req_addr;
    in_e.err  = in_err;
    in_e.data = in_err ? '0 : mem_q[bus.req_addr[MEM_AW+1:2]];
  end

  if (LATENCY == 1) begin : g_direct
    assign push_v = accept;
    assign push_e = in_e;
  end else begin : g_pipe
    logic [LATENCY-2:0] vld_q, vld_d;
    entry_t             stg_q [LATENCY-1];

    // A request accepted in the flush cycle enters stage 0 and survives as the redirect target.
    always_comb begin
      vld_d    = '0;
      vld_d[0] = accept;
      for (int i = 1; i < LATENCY - 1; i++) vld_d[i] = vld_q[i-1] && !bus.flush;
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= vld_d;
    end

    always_ff @(posedge clk) begin
      stg_q[0] <= in_e;
      for (int i = 1; i < LATENCY - 1; i++) stg_q[i] <= stg_q[i-1];
    end

    assign push_v = vld_q[LATENCY-2] && !bus.flush;
    assign push_e = stg_q[LATENCY-2];
  end

  // NOTE: every next-state signal gets its default first, so no path leaves a latch behind.
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    wr_idx = wr_q;
    cnt_d  = cnt_q;
    occ_d  = occ_q;
    if (bus.flush) begin
      wr_idx = '0;
      rd_d   = '0;
      wr_d   = push_v ? ptr_inc('0) : '0;
      cnt_d  = CNT_W'(push_v);
      occ_d  = CNT_W'(accept);
    end else begin
      if (push_v) wr_d = ptr_inc(wr_q);
      if (pop)    rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CNT_W'(push_v) - CNT_W'(pop);
      occ_d = occ_q + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      occ_q <= occ_d;
    end
  end

  // NOTE: storage arrays carry no reset; the pointers and valids alone define what is live.
  always_ff @(posedge clk) begin
    if (push_v) fifo_q[wr_idx] <= push_e;
  end

  assign ld_idx       = bus.ld_addr[ADDR_W-1:2];
  assign ld_hit       = bus.ld_we && ({1'b0, ld_idx} < DEPTH_LIM);
  assign unused_ld_lo = ^bus.ld_addr[1:0];

  always_ff @(posedge clk) begin
    if (ld_hit) mem_q[bus.ld_addr[MEM_AW+1:2]] <= bus.ld_data;
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push_v && !bus.flush && (cnt_q == FULL_CNT)));
endmodule
